// File: rtl/mm_job_ctrl_pkg.sv
// Shared definitions for the matrix-multiply job sequencer: default sizes and
// the sequencer state encoding.
package mm_job_ctrl_pkg;

  localparam int DW_DEF  = 8;   // operand width
  localparam int NE_DEF  = 8;   // elements per operand matrix
  localparam int TMO_DEF = 15;  // cycles allowed in each EOM wait state

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_READ
  } state_t;

endpackage

// File: rtl/mm_job_ctrl_if.sv
// Host operand/result streams plus the array-side register and STM/EOM
// signals. master = sequencer, slave = host + array environment.
interface mm_job_ctrl_if
  import mm_job_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NE = NE_DEF
);
  localparam int AW = $clog2(2*NE);
  localparam int RW = $clog2(NE);

  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic            stm;
  logic            eom;
  logic [RW-1:0]   rsel;
  logic [2*DW-1:0] rdata;
  logic [2*DW-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            tmo_err;

  modport master (
    input  in_data, in_valid, eom, rdata, out_ready,
    output in_ready, we, waddr, wdata, stm, rsel, out_data, out_valid, busy, tmo_err
  );

  modport slave (
    output in_data, in_valid, eom, rdata, out_ready,
    input  in_ready, we, waddr, wdata, stm, rsel, out_data, out_valid, busy, tmo_err
  );

endinterface

// File: rtl/mm_job_ctrl_tmo_cnt.sv
// Loadable down-counter with a zero flag; bounds the EOM wait states.
module mm_job_ctrl_tmo_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mm_job_ctrl.sv
// Host-side sequencer for the matrix-multiply array: loads 2*NE operands,
// pulses STM, tracks EOM with a timeout, then streams NE results.
module mm_job_ctrl
  import mm_job_ctrl_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int NE  = NE_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  mm_job_ctrl_if.master bus
);

  localparam int AW = $clog2(2*NE);
  localparam int RW = $clog2(NE);
  localparam int TW = $clog2(TMO+1);

  state_t        state, state_nx;
  logic [AW-1:0] wcnt, wcnt_nx;
  logic [RW-1:0] rcnt, rcnt_nx;
  logic          tmo_err_q, tmo_err_nx;
  logic          tmo_load, tmo_dec, tmo_zero;
  logic          in_ready_c, accept;

  mm_job_ctrl_tmo_cnt #(.W(TW)) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmo_load),
    .load_val (TW'(TMO-1)),
    .dec      (tmo_dec),
    .zero     (tmo_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      rcnt      <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state     <= state_nx;
      wcnt      <= wcnt_nx;
      rcnt      <= rcnt_nx;
      tmo_err_q <= tmo_err_nx;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_nx   = state;
    wcnt_nx    = wcnt;
    rcnt_nx    = rcnt;
    tmo_err_nx = tmo_err_q;
    tmo_load   = 1'b0;
    tmo_dec    = 1'b0;

    // Gated by rst_n so the host sees no readiness while reset is held.
    in_ready_c = rst_n && ((state == ST_IDLE) || (state == ST_LOAD));
    accept     = in_ready_c && bus.in_valid;

    unique case (state)
      ST_IDLE: if (accept) begin
        wcnt_nx    = AW'(1);
        tmo_err_nx = 1'b0;
        state_nx   = ST_LOAD;
      end
      ST_LOAD: if (accept) begin
        if (wcnt == AW'(2*NE-1)) begin
          wcnt_nx  = '0;
          state_nx = ST_START;
        end else begin
          wcnt_nx  = wcnt + AW'(1);
        end
      end
      ST_START: begin
        tmo_load = 1'b1;
        state_nx = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!bus.eom) begin
          tmo_load = 1'b1;
          state_nx = ST_WAIT_HI;
        end else if (tmo_zero) begin
          tmo_err_nx = 1'b1;
          state_nx   = ST_IDLE;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      ST_WAIT_HI: begin
        if (bus.eom) begin
          state_nx = ST_READ;
        end else if (tmo_zero) begin
          tmo_err_nx = 1'b1;
          state_nx   = ST_IDLE;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      ST_READ: if (bus.out_ready) begin
        if (rcnt == RW'(NE-1)) begin
          rcnt_nx  = '0;
          state_nx = ST_IDLE;
        end else begin
          rcnt_nx  = rcnt + RW'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    bus.in_ready  = in_ready_c;
    bus.we        = accept;
    bus.waddr     = wcnt;
    bus.wdata     = rst_n ? bus.in_data : {DW{1'b0}};
    bus.stm       = (state == ST_START);
    bus.rsel      = rcnt;
    bus.out_valid = (state == ST_READ);
    bus.out_data  = (state == ST_READ) ? bus.rdata : {2*DW{1'b0}};
    bus.busy      = (state != ST_IDLE);
    bus.tmo_err   = tmo_err_q;
  end

endmodule

// File: tb/tb_mm_job_ctrl.sv
// Randomized bench for mm_job_ctrl: host/array models drive the DUT, and a
// per-cycle reference of the job protocol checks every observable output.
module tb_mm_job_ctrl;
  import mm_job_ctrl_pkg::*;

  localparam int DW  = 8;
  localparam int NE  = 8;
  localparam int NW  = 2*NE;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mm_job_ctrl_if #(.DW(DW), .NE(NE)) ifc ();

  mm_job_ctrl #(.DW(DW), .NE(NE), .TMO(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Array environment: result registers and EOM behaviour
  logic [2*DW-1:0] res_tbl [NE];
  assign ifc.rdata = res_tbl[ifc.rsel];

  int arr_mode = 0;   // 0 normal, 1 EOM stuck high, 2 EOM low too long
  int drop_dly = 0;
  int lo_len   = 4;
  int rdy_mode = 0;   // 0 always ready, 1 pattern 1,0,0, 2 random

  initial begin
    bit s;
    bit active;
    int t;
    active  = 0;
    t       = 0;
    ifc.eom = 1'b1;
    forever begin
      @(negedge clk);
      s = ifc.stm;
      @(posedge clk);
      #1;
      if (s) begin
        t      = 0;
        active = (arr_mode != 1);
      end
      if (active) begin
        t++;
        if (t == drop_dly + 1) ifc.eom = 1'b0;
        if (t == drop_dly + 1 + ((arr_mode == 2) ? 40 : lo_len)) begin
          ifc.eom = 1'b1;
          active  = 0;
        end
      end
    end
  end

  initial begin
    int k;
    k = 0;
    ifc.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      k++;
      case (rdy_mode)
        0:       ifc.out_ready = 1'b1;
        1:       ifc.out_ready = (k % 3 == 0);
        default: ifc.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model of the job protocol
  typedef enum {M_OPEN, M_STM, M_WLO, M_WHI, M_READ} mph_t;
  mph_t        ph      = M_OPEN;
  int          wcnt    = 0;
  int          rcnt    = 0;
  int          tcnt    = 0;
  int          n_res   = 0;
  int          n_stm   = 0;
  bit          tmo_exp = 0;
  logic [DW-1:0] opmem [NW];
  logic [DW-1:0] sent_q [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      ph      = M_OPEN;
      wcnt    = 0;
      rcnt    = 0;
      tcnt    = 0;
      tmo_exp = 0;
    end else begin
      check("in_ready",  32'(ifc.in_ready),  32'(ph == M_OPEN));
      check("we",        32'(ifc.we),        32'(ifc.in_valid && ph == M_OPEN));
      check("stm",       32'(ifc.stm),       32'(ph == M_STM));
      check("out_valid", 32'(ifc.out_valid), 32'(ph == M_READ));
      check("busy",      32'(ifc.busy),      32'(ph != M_OPEN || wcnt != 0));
      check("tmo_err",   32'(ifc.tmo_err),   32'(tmo_exp));
      if (ph == M_OPEN && ifc.in_valid) begin
        check("waddr", 32'(ifc.waddr), 32'(wcnt));
        check("wdata", 32'(ifc.wdata), 32'(ifc.in_data));
      end
      if (ph == M_READ) begin
        check("rsel",     32'(ifc.rsel),     32'(rcnt));
        check("out_data", 32'(ifc.out_data), 32'(res_tbl[rcnt]));
      end

      case (ph)
        M_OPEN: if (ifc.in_valid) begin
          opmem[ifc.waddr] = ifc.wdata;
          if (wcnt == 0) tmo_exp = 0;
          if (wcnt == NW-1) begin
            wcnt = 0;
            ph   = M_STM;
          end else begin
            wcnt++;
          end
        end
        M_STM: begin
          int mism;
          mism = 0;
          for (int i = 0; i < NW; i++) begin
            if (sent_q.size() == 0) mism++;
            else if (opmem[i] !== sent_q.pop_front()) mism++;
          end
          check("operands", 32'(mism), 32'(0));
          n_stm++;
          tcnt = 0;
          ph   = M_WLO;
        end
        M_WLO: begin
          if (!ifc.eom) begin
            tcnt = 0;
            ph   = M_WHI;
          end else if (++tcnt == TMO) begin
            tmo_exp = 1;
            ph      = M_OPEN;
          end
        end
        M_WHI: begin
          if (ifc.eom) begin
            rcnt = 0;
            ph   = M_READ;
          end else if (++tcnt == TMO) begin
            tmo_exp = 1;
            ph      = M_OPEN;
          end
        end
        M_READ: if (ifc.out_ready) begin
          n_res++;
          if (rcnt == NE-1) ph = M_OPEN;
          else rcnt++;
        end
        default: ph = M_OPEN;
      endcase
    end
  end

  // Host-side drivers
  task automatic drive_word(input logic [DW-1:0] w, input int gap);
    int n;
    sent_q.push_back(w);
    ifc.in_valid = 1'b1;
    ifc.in_data  = w;
    n = 0;
    @(negedge clk);
    while (!ifc.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("accept_bound", 32'(n < 300), 32'(1));
    @(posedge clk);
    #1;
    if (gap > 0) begin
      ifc.in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (ifc.busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_bound", 32'(n < 400), 32'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int glo, input int ghi, input bit seq,
                         input int njobs, input bit abort_exp, input bit keep);
    int base_res;
    int base_stm;
    base_res = n_res;
    base_stm = n_stm;
    for (int i = 0; i < NW; i++)
      drive_word(seq ? DW'(i + 1) : DW'($urandom), (i == NW-1) ? 0 : $urandom_range(glo, ghi));
    if (!keep) begin
      ifc.in_valid = 1'b0;
      wait_idle();
      check("results",  32'(n_res - base_res), abort_exp ? 32'(0) : 32'(NE*njobs));
      check("stm_count", 32'(n_stm - base_stm), 32'(njobs));
      check("tmo_end",  32'(ifc.tmo_err), 32'(abort_exp));
      check("busy_end", 32'(ifc.busy), 32'(0));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  32'(ifc.in_ready),  32'(0));
    check({tag, "_we"},        32'(ifc.we),        32'(0));
    check({tag, "_waddr"},     32'(ifc.waddr),     32'(0));
    check({tag, "_wdata"},     32'(ifc.wdata),     32'(0));
    check({tag, "_stm"},       32'(ifc.stm),       32'(0));
    check({tag, "_rsel"},      32'(ifc.rsel),      32'(0));
    check({tag, "_out_data"},  32'(ifc.out_data),  32'(0));
    check({tag, "_out_valid"}, 32'(ifc.out_valid), 32'(0));
    check({tag, "_busy"},      32'(ifc.busy),      32'(0));
    check({tag, "_tmo_err"},   32'(ifc.tmo_err),   32'(0));
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    #1;
    sent_q.delete();
    ifc.in_valid = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(ifc.in_ready), 32'(1));
    check("post_rst_waddr",    32'(ifc.waddr),    32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h5a;
    for (int i = 0; i < NE; i++) res_tbl[i] = 16'h0100 + 16'(i);
    #2;
    check_all_zero("rst");
    release_reset();

    // Reset mid-LOAD after 5 words, with IN_VALID still asserted
    for (int i = 0; i < 5; i++) drive_word(DW'(8'hA0 + i), 0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    release_reset();

    // Directed job: words 0x01..0x10, results 0x0100+RSEL
    run_job(0, 0, 1, 1, 0, 0);

    // Backpressure 1,0,0 pattern
    rdy_mode = 1;
    for (int i = 0; i < NE; i++) res_tbl[i] = 16'($urandom);
    run_job(0, 1, 0, 1, 0, 0);
    rdy_mode = 0;

    // EOM stuck high: WAIT_LO timeout
    arr_mode = 1;
    run_job(0, 0, 0, 1, 1, 0);
    // EOM low too long: WAIT_HI timeout
    arr_mode = 2;
    run_job(0, 0, 0, 1, 1, 0);
    repeat (40) @(posedge clk);
    #1;
    arr_mode = 0;

    // IN_VALID held through START..READ; next job waits for the 8th result
    for (int i = 0; i < NE; i++) res_tbl[i] = 16'($urandom);
    rdy_mode = 2;
    run_job(0, 0, 0, 1, 0, 1);
    run_job(0, 0, 0, 2, 0, 0);

    // IN_VALID gaps of 3 cycles during LOAD
    rdy_mode = 0;
    run_job(3, 3, 0, 1, 0, 0);

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      bit ab;
      ab       = ($urandom_range(0, 5) == 0);
      arr_mode = ab ? 1 : 0;
      drop_dly = $urandom_range(0, 5);
      lo_len   = $urandom_range(1, 8);
      rdy_mode = $urandom_range(0, 2);
      for (int i = 0; i < NE; i++) res_tbl[i] = 16'($urandom);
      run_job(0, 2, 0, 1, ab, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
